// File: rtl/acc_host_pkg.sv
// Shared types and constants for the accelerator host-side initiator.
package acc_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        WAIT_FIN,
        READ,
        DONE,
        ERR
    } state_t;

    localparam int XW = 8;
    localparam int RW = 9;

    localparam int DEF_N_X     = 32;
    localparam int DEF_N_RES   = 16;
    localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/acc_wdog.sv
// Loadable up-counter with clear and enable; flags the terminal count TIMEOUT-1.
module acc_wdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       load,
    input  logic [$clog2(TIMEOUT)-1:0] load_val,
    input  logic                       en,
    output logic                       tc
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

    logic [W-1:0] count_reg;

    // Saturates at the terminal count so it can never wrap inside a job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != TERM)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == TERM);

endmodule

// File: rtl/acc_host_master.sv
// Host-side job sequencer: start pulse, N_X input bytes, wait for finish,
// then N_RES result words over the cs_n/ry handshake, with a shared watchdog.
module acc_host_master
    import acc_host_pkg::*;
#(
    parameter int N_X     = DEF_N_X,
    parameter int N_RES   = DEF_N_RES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          src_valid,
    input  logic [XW-1:0] src_data,
    output logic          src_ready,
    output logic          start_in,
    output logic          valid_input,
    output logic [XW-1:0] X_load,
    input  logic          finish,
    output logic          cs_n,
    input  logic          ry,
    input  logic [RW-1:0] read_data,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BCW = $clog2(N_X + 1);
    localparam int RCW = $clog2(N_RES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(N_X - 1);
    localparam logic [RCW-1:0] LAST_RES  = RCW'(N_RES - 1);

    state_t         state_reg;
    logic [BCW-1:0] byte_cnt_reg;
    logic [RCW-1:0] res_cnt_reg;
    logic           src_ready_reg;
    logic           start_in_reg;
    logic           valid_input_reg;
    logic [XW-1:0]  x_load_reg;
    logic           cs_n_reg;
    logic           res_valid_reg;
    logic [RW-1:0]  res_data_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;

    logic wd_clr;
    logic wd_en;
    logic wd_tc;
    logic ry_acc;

    assign ry_acc = ry && !cs_n_reg && (state_reg == READ);

    // Watchdog runs only while waiting on the accelerator; any progress restarts it.
    always_comb begin
        wd_clr = 1'b1;
        wd_en  = 1'b0;
        case (state_reg)
            WAIT_FIN: begin
                wd_clr = finish;
                wd_en  = !finish;
            end
            READ: begin
                wd_clr = ry_acc;
                wd_en  = !ry_acc;
            end
            default: ;
        endcase
    end

    acc_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wd_en),
        .tc       (wd_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= '0;
            res_cnt_reg     <= '0;
            src_ready_reg   <= 1'b0;
            start_in_reg    <= 1'b0;
            valid_input_reg <= 1'b0;
            x_load_reg      <= '0;
            cs_n_reg        <= 1'b1;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            start_in_reg    <= 1'b0;
            valid_input_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        state_reg    <= START;
                        start_in_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    state_reg     <= LOAD;
                    src_ready_reg <= 1'b1;
                end
                LOAD: begin
                    if (src_valid && src_ready_reg) begin
                        x_load_reg      <= src_data;
                        valid_input_reg <= 1'b1;
                        byte_cnt_reg    <= byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            src_ready_reg <= 1'b0;
                            state_reg     <= WAIT_FIN;
                        end
                    end
                end
                WAIT_FIN: begin
                    if (finish) begin
                        state_reg <= READ;
                        cs_n_reg  <= 1'b0;
                    end else if (wd_tc) begin
                        state_reg <= ERR;
                        err_reg   <= 1'b1;
                    end
                end
                READ: begin
                    if (ry_acc) begin
                        res_valid_reg <= 1'b1;
                        res_data_reg  <= read_data;
                        res_cnt_reg   <= res_cnt_reg + 1'b1;
                        if (res_cnt_reg == LAST_RES) begin
                            cs_n_reg  <= 1'b1;
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end else if (wd_tc) begin
                        cs_n_reg  <= 1'b1;
                        state_reg <= ERR;
                        err_reg   <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    byte_cnt_reg <= '0;
                    res_cnt_reg  <= '0;
                end
                ERR: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    byte_cnt_reg  <= '0;
                    res_cnt_reg   <= '0;
                    cs_n_reg      <= 1'b1;
                    src_ready_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign src_ready   = src_ready_reg;
    assign start_in    = start_in_reg;
    assign valid_input = valid_input_reg;
    assign X_load      = x_load_reg;
    assign cs_n        = cs_n_reg;
    assign res_valid   = res_valid_reg;
    assign res_data    = res_data_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: doc/acc_host_master.md
Name: acc_host_master

Overview:
- Host-side initiator for the accelerator command/data interface.
- Sequences one job:
  - pulses start_in;
  - streams N_X input bytes on X_load/valid_input;
  - waits for finish;
  - reads N_RES result words through the cs_n/ry/read_data handshake.
- Sits in the chip/FPGA wrapper between a byte source (host FIFO/UART) and the accelerator top.
- Also serves as the reusable driver in system-level benches.

Parameters:
- N_X, 32, input bytes per job (≥1)
- N_RES, 16, result words per job (≥1)
- TIMEOUT, 4096, max cycles allowed in WAIT_FIN and in READ before abort (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- go  in  1  job request; sampled in IDLE only
- src_valid  in  1  source byte valid
- src_data  in  8  source byte
- src_ready  out  1  master accepts byte this cycle
- start_in  out  1  accelerator start pulse
- valid_input  out  1  X_load carries a valid byte
- X_load  out  8  input byte to accelerator
- finish  in  1  accelerator compute complete (level)
- cs_n  out  1  read select, active-low
- ry  in  1  read_data valid this cycle
- read_data  in  9  result word
- res_valid  out  1  res_data valid (1-cycle pulse per word)
- res_data  out  9  captured result word
- busy  out  1  job in progress (state ≠ IDLE)
- done  out  1  1-cycle pulse on successful job end
- err  out  1  1-cycle pulse on timeout abort

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1; all other outputs 0; state=IDLE; all counters 0.
- Reset mid-job forces these values immediately. No partial-job resume.

States:
- IDLE: go=1 → START. go is ignored in every other state.
- START: start_in=1 for exactly one cycle (cycle after go sampled) → LOAD.
- LOAD:
  - src_ready=1.
  - On src_valid&src_ready: next cycle X_load=src_data, valid_input=1, byte_cnt++. Otherwise valid_input=0 and X_load holds its value.
  - Source gaps are allowed.
  - When the N_X-th byte is accepted: src_ready drops the next cycle → WAIT_FIN.
  - finish is ignored in LOAD.
- WAIT_FIN:
  - Watchdog counts from 0.
  - finish=1 → READ, watchdog cleared.
  - Watchdog reaches TIMEOUT-1 with finish=0 → ERR.
- READ:
  - cs_n=0 from the first READ cycle.
  - Each cycle ry=1: next cycle res_valid=1, res_data=read_data, res_cnt++. Latency is 1 cycle.
  - ry is ignored whenever cs_n=1.
  - Watchdog restarts on every accepted word. If it reaches TIMEOUT-1 without ry → ERR.
  - On the N_RES-th word: cs_n=1 next cycle → DONE. Extra ry in that same cycle is ignored.
- DONE: done=1 for one cycle, counters cleared → IDLE.
- ERR: err=1 for one cycle; cs_n=1, src_ready=0, valid_input=0 → IDLE.

Other rules:
- Sink has no backpressure. The consumer must accept res_valid every cycle.
- byte_cnt width is clog2(N_X+1), res_cnt width is clog2(N_RES+1), watchdog width is clog2(TIMEOUT). No wrap within a job.
- finish and ry asserted together in WAIT_FIN: transition to READ only. That ry is not captured, because cs_n is still 1.
- go held high continuously: a new job starts on the cycle after DONE/ERR returns to IDLE.

Decomposition:
- Package acc_host_pkg holds:
  - state enum {IDLE, START, LOAD, WAIT_FIN, READ, DONE, ERR};
  - XW=8 and RW=9 width constants;
  - default N_X/N_RES/TIMEOUT constants.
- Sub-module acc_wdog: loadable up-counter with clear, enable and terminal-count flag (TIMEOUT parameter). Instantiated once, shared by WAIT_FIN and READ.

Test Plan:
- Nominal job (N_X=4, N_RES=2): go@c0, source bytes 0x11,0x22,0x33,0x44 back-to-back → start_in=1 only at c1; valid_input=1 at c3..c6 with those bytes; finish@c10; ry with 0x1A5, 0x0FF → res_valid two pulses with those values; cs_n low only while READ; done single pulse; busy low after.
- Source gaps: src_valid 1,0,0,1,1,0,1 → valid_input mirrors accepted bytes one cycle later, exactly 4 bytes; X_load holds during gaps.
- Finish timeout (TIMEOUT=8): finish never asserted → err pulse exactly 8 cycles after WAIT_FIN entry; cs_n stays 1; return to IDLE; second job runs normally.
- Read stall timeout: one word received, then ry held 0 → err after TIMEOUT cycles; cs_n returns to 1; res_valid count = 1.
- Async reset during READ (mid-cycle): cs_n=1 and res_valid=0 immediately, not at the next edge; state IDLE; a fresh go works. Also: go pulsed during LOAD is ignored (only one start_in per job).
- Corners: ry while cs_n=1 before READ produces no res_valid; finish during LOAD does not shorten loading (all N_X bytes still sent).
